// File: rtl/linked_list_pop_arbiter.sv
// Pops one non-empty logical queue of the shared linked-list FIFO per cycle into a 2-entry valid/ready buffer.
// Define LL_POP_ARB_FIXED_PRIO_EN for lowest-index-first grant; default build is round-robin.
module linked_list_pop_arbiter #(
  parameter int WIDTH     = 4,
  parameter int NUM_FIFOS = 2,
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FIFOS-1:0] empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 pop,
  output logic [SEL_WIDTH-1:0] pop_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_sel
);

  logic [SEL_WIDTH-1:0]          last_q, last_d;
  logic                          rd_ptr_q, rd_ptr_d;
  logic                          wr_ptr_q, wr_ptr_d;
  logic [1:0]                    cnt_q, cnt_d;
  logic [1:0][WIDTH-1:0]         buf_data_q, buf_data_d;
  logic [1:0][SEL_WIDTH-1:0]     buf_sel_q, buf_sel_d;

  logic [SEL_WIDTH-1:0] grant;
  logic [SEL_WIDTH-1:0] idx;
  logic                 any_req;
  logic                 deq;

  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
`ifdef LL_POP_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_FIFOS; i++) begin
      idx = SEL_WIDTH'(i);
      if (!any_req && !empty[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
`else
    // Start one past the last winner; the last winner is considered only after all others.
    for (int k = 1; k <= NUM_FIFOS; k++) begin
      idx = SEL_WIDTH'((int'(last_q) + k) % NUM_FIFOS);
      if (!any_req && !empty[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
`endif
  end

  // Gating with rst keeps the FIFO untouched while the block is held in reset.
  assign pop       = rst & any_req & (cnt_q != 2'd2);
  assign pop_sel   = grant;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = buf_data_q[rd_ptr_q];
  assign out_sel   = buf_sel_q[rd_ptr_q];
  assign deq       = out_valid & out_ready;

  always_comb begin
    last_d     = last_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    buf_data_d = buf_data_q;
    buf_sel_d  = buf_sel_q;
    if (pop) begin
      buf_data_d[wr_ptr_q] = fifo_data;
      buf_sel_d[wr_ptr_q]  = grant;
      wr_ptr_d             = ~wr_ptr_q;
      last_d               = grant;
    end
    if (deq) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, pop} - {1'b0, deq};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q     <= SEL_WIDTH'(NUM_FIFOS - 1);
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      buf_data_q <= '0;
      buf_sel_q  <= '0;
    end else begin
      last_q     <= last_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      buf_data_q <= buf_data_d;
      buf_sel_q  <= buf_sel_d;
    end
  end

endmodule

// File: tb/tb_linked_list_pop_arbiter.sv
// Scoreboard bench for linked_list_pop_arbiter: models the FIFO queues and the arbiter's
// grant rule behaviourally, queues expected words, and a separate monitor checks the output port.
module tb_linked_list_pop_arbiter;
  localparam int W  = 4;
  localparam int N  = 2;
  localparam int SW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  empty = '1;
  logic [W-1:0]  fifo_data = '0;
  logic          pop;
  logic [SW-1:0] pop_sel;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_sel;

  linked_list_pop_arbiter #(.WIDTH(W), .NUM_FIFOS(N)) dut (
    .clk(clk), .rst(rst), .empty(empty), .fifo_data(fifo_data),
    .pop(pop), .pop_sel(pop_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  logic [W-1:0]    fq [N][$];
  logic [SW+W-1:0] sb [$];
  logic [SW+W-1:0] pend;
  bit              pend_v;
  int              last_m;
  int              vectors;
  int              errors;

  function automatic int model_grant(input logic [N-1:0] e, input int lst);
`ifdef LL_POP_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (!e[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (!e[(lst + k) % N]) return (lst + k) % N;
`endif
    return -1;
  endfunction

  task automatic step(input logic rstv, input logic rdy, input int pct);
    int  g;
    bit  exp_pop;
    @(posedge clk);
    if (!rst) begin
      sb.delete();
      pend_v = 0;
      last_m = N - 1;
    end else if (pend_v) begin
      sb.push_back(pend);
      pend_v = 0;
    end
    #1;
    rst       = rstv;
    out_ready = rdy;
    for (int q = 0; q < N; q++)
      if ($urandom_range(99) < pct && fq[q].size() < 8) fq[q].push_back(W'($urandom));
    for (int q = 0; q < N; q++) empty[q] = (fq[q].size() == 0);
    g         = model_grant(empty, last_m);
    exp_pop   = rstv && (sb.size() < 2) && (g >= 0);
    fifo_data = (g >= 0) ? fq[g][0] : W'($urandom);
    #2;
    vectors++;
    if (pop !== exp_pop) begin
      errors++;
      $display("FAIL pop: got %b want %b empty=%b t=%0t", pop, exp_pop, empty, $time);
    end
    if (exp_pop) begin
      vectors++;
      if (pop_sel !== SW'(g)) begin
        errors++;
        $display("FAIL pop_sel: got %0d want %0d empty=%b t=%0t", pop_sel, g, empty, $time);
      end
      pend   = {SW'(g), fq[g][0]};
      pend_v = 1;
      void'(fq[g].pop_front());
      last_m = g;
    end
  endtask

  // Output monitor: compares the presented word against the oldest expected entry.
  initial begin
    bit rprev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        vectors++;
        if (out_valid !== (sb.size() != 0)) begin
          errors++;
          $display("FAIL out_valid: got %b want %b t=%0t", out_valid, sb.size() != 0, $time);
        end
        if (out_valid === 1'b1 && sb.size() > 0) begin
          vectors++;
          if ({out_sel, out_data} !== sb[0]) begin
            errors++;
            $display("FAIL out_word: got sel=%0d data=%h want sel=%0d data=%h t=%0t",
                     out_sel, out_data, sb[0][W], sb[0][W-1:0], $time);
          end
          if (out_ready) void'(sb.pop_front());
        end
      end else if (!rprev) begin
        vectors++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL out_valid_in_reset: got %b want 0 t=%0t", out_valid, $time);
        end
      end
      rprev = rst;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    errors  = 0;
    pend_v  = 0;
    last_m  = N - 1;
    fq[0].push_back(4'h3); fq[0].push_back(4'h4);
    fq[1].push_back(4'h9); fq[1].push_back(4'hA);

    // reset with both queues non-empty, then ordered alternation
    repeat (2) step(1'b0, 1'b1, 0);
    repeat (6) step(1'b1, 1'b1, 0);

    // single queue, then nothing to pop
    repeat (5) fq[1].push_back(W'($urandom));
    repeat (8) step(1'b1, 1'b1, 0);

    // backpressure then drain
    for (int q = 0; q < N; q++) repeat (4) fq[q].push_back(W'($urandom));
    repeat (5) step(1'b1, 1'b0, 0);
    repeat (8) step(1'b1, 1'b1, 0);

    // reset with a full buffer
    for (int q = 0; q < N; q++) repeat (4) fq[q].push_back(W'($urandom));
    repeat (3) step(1'b1, 1'b0, 0);
    repeat (2) step(1'b0, 1'b0, 0);
    repeat (4) step(1'b1, 1'b1, 0);

    // randomized traffic
    for (int blk = 0; blk < 6; blk++) begin
      int pct;
      int rdy_pct;
      pct     = int'($urandom_range(90, 15));
      rdy_pct = int'($urandom_range(100, 20));
      repeat (500)
        step($urandom_range(199) != 0, $urandom_range(99) < rdy_pct, pct);
    end

    repeat (6) step(1'b1, 1'b1, 0);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/linked_list_pop_arbiter.md
# linked_list_pop_arbiter

Downstream consumer of the shared linked-list FIFO (`linked_list_fifo`). Each cycle it picks one non-empty logical queue and drives `pop`/`pop_sel`. It captures the popped word with its queue id into a 2-entry output buffer and presents it on a valid/ready interface to the next stage. By construction it never pops an empty queue, so the FIFO's pop-on-empty environment constraint is met.

## Interface
- `WIDTH`, 4, data word width; must equal the FIFO's `WIDTH`
- `NUM_FIFOS`, 2, number of logical queues; must be ≥ 2
- `SEL_WIDTH`, `$clog2(NUM_FIFOS)`, queue-select width
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-low reset: state resets at a rising edge when `rst`=0
- `empty`  in  NUM_FIFOS  per-queue empty flags from the FIFO
- `fifo_data`  in  WIDTH  FIFO `data_out`: head of queue `pop_sel`, valid combinationally while `pop`=1
- `pop`  out  1  pop strobe to the FIFO
- `pop_sel`  out  SEL_WIDTH  queue being popped
- `out_valid`  out  1  output buffer holds a word
- `out_ready`  in  1  downstream accepts the word this cycle
- `out_data`  out  WIDTH  oldest buffered word
- `out_sel`  out  SEL_WIDTH  queue id of `out_data`

## Operation
- State:
  - `last` (SEL_WIDTH): last granted queue.
  - 2-entry buffer of {sel, data}: `rd_ptr` and `wr_ptr`, 1 bit each.
  - `cnt`, 2 bits, range 0..2.
- Reset values: `last` = NUM_FIFOS-1, so queue 0 wins first. `cnt` = 0, `rd_ptr` = `wr_ptr` = 0.
- Output reset values: `out_valid`=0, `pop`=0. `out_data`, `out_sel` read entry 0, which resets to 0.
- Grant search (round-robin):
  - Search queues `last`+1, `last`+2, … wrapping modulo NUM_FIFOS.
  - Grant the first queue with `empty[i]`=0.
  - `last` itself is checked last.
- `pop` = `cnt`<2 AND any `empty[i]`=0. `pop_sel` = the granted queue.
- When `pop` and `pop_sel` are both 0, the value of `pop_sel` is don't-care.
- Boundary: `pop`=1 implies `empty[pop_sel]`=0 in the same cycle. This is a hard invariant.
- On `pop`:
  - Write {`pop_sel`, `fifo_data`} at `wr_ptr`; toggle `wr_ptr`.
  - `last` ← `pop_sel`.
- Dequeue on `out_valid` & `out_ready`: toggle `rd_ptr`.
- `cnt` ← `cnt` + pop − dequeue. A simultaneous pop and dequeue leaves `cnt` unchanged.
- `out_valid` = (`cnt`≠0). `out_data`/`out_sel` = entry at `rd_ptr`.
- While `out_valid`=1 and `out_ready`=0, `out_data`/`out_sel` hold stable.
- `pop` does not depend on `out_ready`, so there is no combinational ready→pop path.
- Reset mid-operation:
  - Buffered words are discarded and `cnt` returns to 0.
  - `pop` is 0 in any cycle with `rst`=0, so the FIFO is never popped during reset.
- The block never pushes into the FIFO and has no view of `full`.

## Timing
- Pop-to-output latency is 1 cycle: a word popped at edge t is visible on `out_data` with `out_valid`=1 after edge t.
- Throughput:
  - 1 word/cycle sustained when `out_ready`=1 and any queue is non-empty.
  - With `cnt`=1 steady state, pop and dequeue happen every cycle.
- Backpressure:
  - After `out_ready` drops, at most 2 words are buffered.
  - `pop` deasserts in the cycle `cnt` reaches 2.
- `pop`/`pop_sel` are combinational from `empty`, `cnt` and `last`. There is no path from `fifo_data`.
- `empty` must reflect FIFO state after the previous edge, i.e. same-cycle FIFO outputs.

## Configuration
- `LL_POP_ARB_FIXED_PRIO_EN` defined:
  - The grant is the lowest-index non-empty queue.
  - `last` is still recorded but ignored by the search.
- Not defined: round-robin as described above (default).
- All other behaviour is identical in both builds.

## Test plan
- Reset then idle: `rst`=0 for 2 cycles with `empty`=2'b00 → `pop`=0 and `out_valid`=0 throughout reset. First cycle after reset: `pop`=1, `pop_sel`=0.
- Round-robin alternation: both queues non-empty and `out_ready`=1 → `pop_sel` sequence 0,1,0,1. `out_sel` follows one cycle later, and `fifo_data` values 3,9,4,A appear in order on `out_data`.
- Single queue: `empty`=2'b01 → `pop_sel`=1 every cycle. `pop`=0 when `empty`=2'b11.
- Backpressure: `out_ready`=0 with both queues non-empty → exactly 2 pops, then `pop`=0. `out_data` holds the first word. Raising `out_ready` drains 2 words and pops resume in the same cycle `cnt` drops below 2.
- Reset mid-stream with `cnt`=2 → `out_valid`=0 after the edge and no pop while `rst`=0.
- `LL_POP_ARB_FIXED_PRIO_EN` with both non-empty → `pop_sel`=0 on every pop until `empty[0]`=1.
